// File: rtl/rf_wr_arbiter_if.sv
// Writeback bus between the ALU/LSU writeback sources, the flush line and the
// register-file write port. The master side is the pipeline/register file
// environment; the slave side is the arbiter.
interface rf_wr_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              i_alu_valid;
   logic [6:0]        i_alu_opcode;
   logic [4:0]        i_alu_rd;
   logic [DATA_W-1:0] i_alu_data;
   logic              o_alu_ready;
   logic              i_lsu_valid;
   logic [4:0]        i_lsu_rd;
   logic [DATA_W-1:0] i_lsu_data;
   logic              o_lsu_ready;
   logic              i_flush;
   logic              o_rf_wr;
   logic [4:0]        o_rf_rd;
   logic [DATA_W-1:0] o_rf_data;
   logic [CNT_W-1:0]  o_conflict_cnt;

   modport master (
      output i_alu_valid, i_alu_opcode, i_alu_rd, i_alu_data,
      output i_lsu_valid, i_lsu_rd, i_lsu_data, i_flush,
      input  o_alu_ready, o_lsu_ready,
      input  o_rf_wr, o_rf_rd, o_rf_data, o_conflict_cnt
   );

   modport slave (
      input  i_alu_valid, i_alu_opcode, i_alu_rd, i_alu_data,
      input  i_lsu_valid, i_lsu_rd, i_lsu_data, i_flush,
      output o_alu_ready, o_lsu_ready,
      output o_rf_wr, o_rf_rd, o_rf_data, o_conflict_cnt
   );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter. Picks one writeback per cycle between the
// ALU and the LSU load-return path, LSU first, but forces the ALU through once
// it has lost MAX_WAIT cycles in a row. Non-writing instructions are acked
// without using the port. The write is presented one cycle after the grant.
module rf_wr_arbiter #(
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 3,
   parameter int CNT_W    = 16
) (
   input  logic            clk,
   input  logic            rst,
   rf_wr_arbiter_if.slave  bus
);
   localparam int              WAIT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
   localparam logic [6:0]      OP_BRANCH = 7'b1100011;
   localparam logic [6:0]      OP_STORE  = 7'b0100011;

   logic              alu_needs;
   logic              lsu_needs;
   logic              alu_grant;
   logic              lsu_grant;
   logic [WAIT_W-1:0] wait_cnt;
   logic [CNT_W-1:0]  conflict_cnt;
   logic              vld_p1;
   logic [4:0]        rd_p1;
   logic [DATA_W-1:0] data_p1;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
      return (v == WAIT_MAX) ? v : v + WAIT_W'(1);
   endfunction

   // Classify requests and pick the winner for this cycle.
   always_comb begin
      alu_needs = bus.i_alu_valid & ~bus.i_flush & (bus.i_alu_rd != 5'd0) &
                  (bus.i_alu_opcode != OP_BRANCH) & (bus.i_alu_opcode != OP_STORE);
      lsu_needs = bus.i_lsu_valid & (bus.i_lsu_rd != 5'd0);
      alu_grant = alu_needs & (~lsu_needs | (wait_cnt == WAIT_MAX));
      lsu_grant = lsu_needs & ~alu_grant;
   end

   // A request is accepted when it wins or when it has nothing to write.
   assign bus.o_alu_ready = ~rst & bus.i_alu_valid & (~alu_needs | alu_grant);
   assign bus.o_lsu_ready = ~rst & bus.i_lsu_valid & (~lsu_needs | lsu_grant);

   // ---- stage p1: registered write port ----
   // Capture the granted write; address/data hold when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         rd_p1   <= '0;
         data_p1 <= '0;
      end else begin
         vld_p1 <= alu_grant | lsu_grant;
         if (alu_grant) begin
            rd_p1   <= bus.i_alu_rd;
            data_p1 <= bus.i_alu_data;
         end else if (lsu_grant) begin
            rd_p1   <= bus.i_lsu_rd;
            data_p1 <= bus.i_lsu_data;
         end
      end
   end

   // Count consecutive cycles the ALU lost to the LSU; any other outcome clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (alu_needs & lsu_grant) begin
         wait_cnt <= sat_inc_wait(wait_cnt);
      end else begin
         wait_cnt <= '0;
      end
   end

   // Saturating statistic of cycles where both sources wanted the port.
   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (alu_needs & lsu_needs) begin
         conflict_cnt <= sat_inc_cnt(conflict_cnt);
      end
   end

   assign bus.o_rf_wr        = vld_p1;
   assign bus.o_rf_rd        = rd_p1;
   assign bus.o_rf_data      = data_p1;
   assign bus.o_conflict_cnt = conflict_cnt;
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios with a queue of expected
// register-file port states, one entry per cycle, compared after each edge.
module tb_rf_wr_arbiter;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 3;
   localparam int CNT_W    = 4;
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_B = 7'b1100011;
   localparam logic [6:0] OP_S = 7'b0100011;

   typedef struct {
      logic        wr;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   exp_conf = 0;
   logic [4:0]  last_rd = '0;
   logic [31:0] last_data = '0;
   exp_t sb[$];

   rf_wr_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   rf_wr_arbiter #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.i_alu_valid  = 1'b0;
      bus.i_alu_opcode = OP_R;
      bus.i_alu_rd     = '0;
      bus.i_alu_data   = '0;
      bus.i_lsu_valid  = 1'b0;
      bus.i_lsu_rd     = '0;
      bus.i_lsu_data   = '0;
      bus.i_flush      = 1'b0;
   endtask

   task automatic push_exp(input logic wr, input logic [4:0] rd, input logic [31:0] d);
      exp_t e;
      if (wr) begin
         last_rd   = rd;
         last_data = d;
      end
      e.wr = wr;
      e.rd = last_rd;
      e.data = last_data;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd5; bus.i_alu_data = 32'h55;
      bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd7; bus.i_lsu_data = 32'h77;
      #1;
      total++;
      if (bus.o_alu_ready !== 1'b0 || bus.o_lsu_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready: alu=%b lsu=%b expected 0/0", bus.o_alu_ready, bus.o_lsu_ready);
      end
      last_rd = '0; last_data = '0; exp_conf = 0;
      push_exp(1'b0, '0, '0);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (bus.o_rf_wr !== e.wr || bus.o_rf_rd !== e.rd || bus.o_rf_data !== e.data ||
          bus.o_conflict_cnt !== CNT_W'(exp_conf)) begin
         bad++;
         $display("FAIL reset_out: wr=%b rd=%0d data=%h cnt=%0d expected 0/0/0/0",
                  bus.o_rf_wr, bus.o_rf_rd, bus.o_rf_data, bus.o_conflict_cnt);
      end
      idle_inputs();
      rst = 1'b0;
      push_exp(1'b0, '0, '0);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (bus.o_rf_wr !== e.wr || bus.o_rf_rd !== e.rd || bus.o_rf_data !== e.data) begin
         bad++;
         $display("FAIL reset_release: wr=%b rd=%0d data=%h expected %b/%0d/%h",
                  bus.o_rf_wr, bus.o_rf_rd, bus.o_rf_data, e.wr, e.rd, e.data);
      end
   endtask

   task automatic test_alu_only();
      exp_t e;
      for (int c = 0; c < 2; c++) begin
         idle_inputs();
         if (c == 0) begin
            bus.i_alu_valid = 1'b1; bus.i_alu_opcode = OP_R;
            bus.i_alu_rd = 5'd5; bus.i_alu_data = 32'h1234;
         end
         #1;
         total++;
         if (bus.o_alu_ready !== (c == 0) || bus.o_lsu_ready !== 1'b0) begin
            bad++;
            $display("FAIL alu_only_ready c%0d: alu=%b lsu=%b expected %b/0", c,
                     bus.o_alu_ready, bus.o_lsu_ready, c == 0);
         end
         push_exp(c == 0, 5'd5, 32'h1234);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (bus.o_rf_wr !== e.wr || bus.o_rf_rd !== e.rd || bus.o_rf_data !== e.data ||
             bus.o_conflict_cnt !== CNT_W'(exp_conf)) begin
            bad++;
            $display("FAIL alu_only_out c%0d: wr=%b rd=%0d data=%h cnt=%0d expected %b/%0d/%h/%0d", c,
                     bus.o_rf_wr, bus.o_rf_rd, bus.o_rf_data, bus.o_conflict_cnt,
                     e.wr, e.rd, e.data, exp_conf);
         end
      end
   endtask

   task automatic test_no_write();
      exp_t e;
      logic [6:0] ops [4];
      logic [4:0] rds [4];
      ops[0] = OP_S; ops[1] = OP_B; ops[2] = OP_R; ops[3] = OP_R;
      rds[0] = 5'd4; rds[1] = 5'd4; rds[2] = 5'd0; rds[3] = 5'd6;
      for (int k = 0; k < 4; k++) begin
         idle_inputs();
         bus.i_alu_valid = 1'b1; bus.i_alu_opcode = ops[k];
         bus.i_alu_rd = rds[k]; bus.i_alu_data = 32'hDEAD0000 + k;
         bus.i_lsu_valid = 1'b1;
         // Last case: flushed ALU alongside an LSU load to x0; nothing writes.
         bus.i_flush = (k == 3);
         bus.i_lsu_rd = (k == 3) ? 5'd0 : 5'd7;
         bus.i_lsu_data = 32'hAA + k;
         #1;
         total++;
         if (bus.o_alu_ready !== 1'b1 || bus.o_lsu_ready !== 1'b1) begin
            bad++;
            $display("FAIL no_write_ready k%0d: alu=%b lsu=%b expected 1/1", k,
                     bus.o_alu_ready, bus.o_lsu_ready);
         end
         push_exp(k != 3, 5'd7, 32'hAA + k);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (bus.o_rf_wr !== e.wr || bus.o_rf_rd !== e.rd || bus.o_rf_data !== e.data ||
             bus.o_conflict_cnt !== CNT_W'(exp_conf)) begin
            bad++;
            $display("FAIL no_write_out k%0d: wr=%b rd=%0d data=%h cnt=%0d expected %b/%0d/%h/%0d", k,
                     bus.o_rf_wr, bus.o_rf_rd, bus.o_rf_data, bus.o_conflict_cnt,
                     e.wr, e.rd, e.data, exp_conf);
         end
      end
   endtask

   task automatic test_starvation();
      exp_t e;
      int   lidx = 0;
      logic alu_win;
      for (int c = 0; c < 5; c++) begin
         idle_inputs();
         bus.i_alu_valid = (c <= 3); bus.i_alu_opcode = OP_R;
         bus.i_alu_rd = 5'd3; bus.i_alu_data = 32'h333;
         bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd8; bus.i_lsu_data = 32'h800 + lidx;
         alu_win = (c == 3);
         #1;
         total++;
         if (bus.o_alu_ready !== alu_win || bus.o_lsu_ready !== !alu_win) begin
            bad++;
            $display("FAIL starve_ready c%0d: alu=%b lsu=%b expected %b/%b", c,
                     bus.o_alu_ready, bus.o_lsu_ready, alu_win, !alu_win);
         end
         if (alu_win) push_exp(1'b1, 5'd3, 32'h333);
         else begin
            push_exp(1'b1, 5'd8, 32'h800 + lidx);
            lidx++;
         end
         if (c <= 3) exp_conf++;
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (bus.o_rf_wr !== e.wr || bus.o_rf_rd !== e.rd || bus.o_rf_data !== e.data ||
             bus.o_conflict_cnt !== CNT_W'(exp_conf)) begin
            bad++;
            $display("FAIL starve_out c%0d: wr=%b rd=%0d data=%h cnt=%0d expected %b/%0d/%h/%0d", c,
                     bus.o_rf_wr, bus.o_rf_rd, bus.o_rf_data, bus.o_conflict_cnt,
                     e.wr, e.rd, e.data, exp_conf);
         end
      end
   endtask

   task automatic test_flush();
      exp_t e;
      int   lidx = 0;
      logic alu_win;
      logic alu_rdy;
      // ALU rd 9 loses twice, is flushed, then a fresh ALU rd 11 must wait a
      // full MAX_WAIT run again before it wins.
      for (int c = 0; c < 8; c++) begin
         idle_inputs();
         bus.i_alu_valid = (c != 7); bus.i_alu_opcode = OP_R;
         bus.i_alu_rd = (c < 3) ? 5'd9 : 5'd11;
         bus.i_alu_data = (c < 3) ? 32'h999 : 32'hBBB;
         bus.i_flush = (c == 2);
         bus.i_lsu_valid = 1'b1; bus.i_lsu_rd = 5'd10; bus.i_lsu_data = 32'hA00 + lidx;
         alu_win = (c == 6);
         alu_rdy = (c == 2) || (c == 6);
         #1;
         total++;
         if (bus.o_alu_ready !== alu_rdy || bus.o_lsu_ready !== !alu_win) begin
            bad++;
            $display("FAIL flush_ready c%0d: alu=%b lsu=%b expected %b/%b", c,
                     bus.o_alu_ready, bus.o_lsu_ready, alu_rdy, !alu_win);
         end
         if (alu_win) push_exp(1'b1, 5'd11, 32'hBBB);
         else begin
            push_exp(1'b1, 5'd10, 32'hA00 + lidx);
            lidx++;
         end
         if (c != 2 && c != 7) exp_conf++;
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (bus.o_rf_wr !== e.wr || bus.o_rf_rd !== e.rd || bus.o_rf_data !== e.data ||
             bus.o_conflict_cnt !== CNT_W'(exp_conf)) begin
            bad++;
            $display("FAIL flush_out c%0d: wr=%b rd=%0d data=%h cnt=%0d expected %b/%0d/%h/%0d", c,
                     bus.o_rf_wr, bus.o_rf_rd, bus.o_rf_data, bus.o_conflict_cnt,
                     e.wr, e.rd, e.data, exp_conf);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      for (int c = 0; c < 3; c++) begin
         idle_inputs();
         rst = (c == 1);
         bus.i_lsu_valid = (c < 2); bus.i_lsu_rd = 5'd12 + c; bus.i_lsu_data = 32'hC00 + c;
         #1;
         total++;
         if (bus.o_lsu_ready !== (c == 0)) begin
            bad++;
            $display("FAIL rstmid_ready c%0d: lsu=%b expected %b", c, bus.o_lsu_ready, c == 0);
         end
         if (c == 1) begin
            last_rd = '0; last_data = '0; exp_conf = 0;
            push_exp(1'b0, '0, '0);
         end else begin
            push_exp(c == 0, 5'd12, 32'hC00);
         end
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (bus.o_rf_wr !== e.wr || bus.o_rf_rd !== e.rd || bus.o_rf_data !== e.data ||
             bus.o_conflict_cnt !== CNT_W'(exp_conf)) begin
            bad++;
            $display("FAIL rstmid_out c%0d: wr=%b rd=%0d data=%h cnt=%0d expected %b/%0d/%h/%0d", c,
                     bus.o_rf_wr, bus.o_rf_rd, bus.o_rf_data, bus.o_conflict_cnt,
                     e.wr, e.rd, e.data, exp_conf);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_saturation();
      exp_t e;
      int   aidx = 0;
      int   lidx = 0;
      logic alu_win;
      // Both sources stream continuously: LSU,LSU,LSU,ALU repeating.
      for (int c = 0; c < 21; c++) begin
         idle_inputs();
         bus.i_alu_valid = (c < 20); bus.i_alu_opcode = OP_R;
         bus.i_alu_rd = 5'd14; bus.i_alu_data = 32'hE00 + aidx;
         bus.i_lsu_valid = (c < 20); bus.i_lsu_rd = 5'd15; bus.i_lsu_data = 32'hF00 + lidx;
         alu_win = (c < 20) && (c % 4 == 3);
         #1;
         total++;
         if (bus.o_alu_ready !== alu_win || bus.o_lsu_ready !== ((c < 20) && !alu_win)) begin
            bad++;
            $display("FAIL sat_ready c%0d: alu=%b lsu=%b expected %b/%b", c,
                     bus.o_alu_ready, bus.o_lsu_ready, alu_win, (c < 20) && !alu_win);
         end
         if (c == 20) push_exp(1'b0, '0, '0);
         else if (alu_win) begin
            push_exp(1'b1, 5'd14, 32'hE00 + aidx);
            aidx++;
         end else begin
            push_exp(1'b1, 5'd15, 32'hF00 + lidx);
            lidx++;
         end
         if (c < 20 && exp_conf < 15) exp_conf++;
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (bus.o_rf_wr !== e.wr || bus.o_rf_rd !== e.rd || bus.o_rf_data !== e.data ||
             bus.o_conflict_cnt !== CNT_W'(exp_conf)) begin
            bad++;
            $display("FAIL sat_out c%0d: wr=%b rd=%0d data=%h cnt=%0d expected %b/%0d/%h/%0d", c,
                     bus.o_rf_wr, bus.o_rf_rd, bus.o_rf_data, bus.o_conflict_cnt,
                     e.wr, e.rd, e.data, exp_conf);
         end
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: left=%0d expected 0", sb.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_alu_only();
      test_no_write();
      test_starvation();
      test_flush();
      test_reset_mid();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Sequences the single register-file write port between two writeback sources: the ALU path (fixed latency) and the LSU load-return path (variable latency).
- Grants one write per cycle and holds the losing requester with valid/ready backpressure.
- Suppresses non-writing instructions (branch, store, rd = x0) and bounds ALU starvation.
- Sits between the execute/memory stages and the register file; drives its write-enable, address and data from a registered output stage.

Parameters:
- DATA_W, 32, width of write data.
- MAX_WAIT, 3, consecutive lost cycles after which a waiting ALU request is forced to win. Legal range 1..15.
- CNT_W, 16, width of the conflict statistics counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- i_alu_valid  in  1  ALU writeback request.
- i_alu_opcode  in  7  opcode of the ALU instruction.
- i_alu_rd  in  5  destination register.
- i_alu_data  in  DATA_W  result.
- o_alu_ready  out  1  ALU request accepted this cycle.
- i_lsu_valid  in  1  load-return request.
- i_lsu_rd  in  5  destination register.
- i_lsu_data  in  DATA_W  load data.
- o_lsu_ready  out  1  LSU request accepted this cycle.
- i_flush  in  1  drop any pending ALU request this cycle.
- o_rf_wr  out  1  register-file write enable.
- o_rf_rd  out  5  register-file write address.
- o_rf_data  out  DATA_W  register-file write data.
- o_conflict_cnt  out  CNT_W  saturating count of arbitration-conflict cycles.

Behaviour:
- Reset: o_rf_wr = 0, o_rf_rd = 0, o_rf_data = 0, o_conflict_cnt = 0, wait counter = 0.
  - o_alu_ready and o_lsu_ready are 0 while rst is high.
  - Reset mid-transfer discards any staged write; no write is issued on the cycle after reset deasserts.
- Request classes:
  - alu_needs_port = i_alu_valid & ~i_flush & (i_alu_rd != 0) & (i_alu_opcode != `B) & (i_alu_opcode != `S).
  - lsu_needs_port = i_lsu_valid & (i_lsu_rd != 0).
  - A valid request that does not need the port is accepted immediately (ready = 1, same cycle) and produces no write.
- Handshake: a requester holds valid, rd, opcode and data stable until ready is sampled high. Ready is combinational from the current inputs and state.
- Arbitration (combinational, per cycle):
  - Only one needs the port: it is granted.
  - Both need it: LSU is granted unless wait_cnt == MAX_WAIT, in which case ALU is granted.
  - Neither needs it: no grant.
- Output stage (1-cycle latency): on the edge after a grant, o_rf_wr = 1 and o_rf_rd / o_rf_data take the granted request's rd and data. Otherwise o_rf_wr = 0, and o_rf_rd / o_rf_data hold their previous values.
- Wait counter (log2 of MAX_WAIT+1 bits):
  - Increments when alu_needs_port and LSU was granted.
  - Clears when ALU is granted or when ~alu_needs_port.
  - Never exceeds MAX_WAIT.
- Conflict counter: increments when both needed the port in a cycle; saturates at all-ones.
- Flush:
  - o_alu_ready = 1 when i_alu_valid & i_flush, and the request is dropped with no write.
  - Flush never affects the LSU path or a write already registered in the output stage.
- Same rd from both sources in one cycle: the loser writes in a later cycle. Ordering is the upstream pipeline's responsibility; the block adds no hazard check.

Test Plan:
- ALU only, opcode `R, rd = 5, data = 0x1234 → o_alu_ready = 1 in cycle 0; o_rf_wr = 1, rd = 5, data = 0x1234 in cycle 1; o_rf_wr = 0 in cycle 2.
- ALU opcode `S or `B, or rd = 0, concurrent with LSU rd = 7, data = 0xAA → both ready in cycle 0; only the LSU write appears in cycle 1; o_conflict_cnt stays 0.
- Both valid continuously (ALU rd = 3, LSU stream rd = 8), MAX_WAIT = 3 → LSU wins cycles 0–2; ALU wins cycle 3 (write rd = 3 in cycle 4); o_conflict_cnt = 4 after cycle 3.
- ALU held waiting behind LSU, then i_flush pulsed for one cycle → ALU acked that cycle with no write; wait counter returns to 0; LSU writes continue uninterrupted.
- rst asserted in the same cycle as an LSU grant → o_rf_wr = 0 on the next cycle; all outputs and counters are 0.
- Saturation: force conflict cycles with CNT_W = 4 → o_conflict_cnt reaches 15 and holds.
